// File: rtl/sync_ram_bwe_clr.sv
`default_nettype none
// ============================================================================
// Module      : sync_ram_bwe_clr
// Description : Single-port synchronous RAM with byte-lane write enables,
//               selectable read-during-write mode and a zero-sweep clear engine.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ram_bwe_clr #(
    parameter int AWIDTH   = 5,
    parameter int DWIDTH   = 16,
    parameter int RDW_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [AWIDTH-1:0]     addr,
    input  logic                  wr,
    input  logic [DWIDTH/8-1:0]   be,
    input  logic [DWIDTH-1:0]     din,
    input  logic                  rd,
    output logic [DWIDTH-1:0]     dout,
    output logic                  dout_valid,
    output logic                  busy,
    output logic                  req_drop
);

    localparam int                c_DEPTH    = 2**AWIDTH;
    localparam int                c_LANES    = DWIDTH/8;
    localparam logic [AWIDTH-1:0] c_LAST     = AWIDTH'(c_DEPTH - 1);
    localparam logic [0:0]        c_ST_CLEAR = 1'b0;
    localparam logic [0:0]        c_ST_READY = 1'b1;

    logic [DWIDTH-1:0] r_mem [c_DEPTH];
    logic [0:0]        r_state;
    logic [AWIDTH-1:0] r_clr_addr;
    logic [DWIDTH-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_busy;
    logic              r_req_drop;

    logic [DWIDTH-1:0] w_rdata;
    logic [DWIDTH-1:0] w_merged;
    logic              w_wr_en;

    assign w_rdata = r_mem[addr];
    assign w_wr_en = (r_state == c_ST_READY) && wr && !clr;

    // Lanes without an enable keep the stored byte, so a read-modify-write is a single edge.
    for (genvar i = 0; i < c_LANES; i++) begin : g_lane
        assign w_merged[8*i +: 8] = be[i] ? din[8*i +: 8] : w_rdata[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (r_state == c_ST_CLEAR) begin
            r_mem[r_clr_addr] <= '0;
        end else if (w_wr_en) begin
            r_mem[addr] <= w_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_CLEAR;
            r_clr_addr   <= '0;
            r_busy       <= 1'b1;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_req_drop   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_READY: begin
                    if (clr) begin
                        r_state      <= c_ST_CLEAR;
                        r_clr_addr   <= '0;
                        r_busy       <= 1'b1;
                        r_dout_valid <= 1'b0;
                        r_req_drop   <= wr | rd;
                    end else begin
                        r_dout_valid <= rd;
                        r_req_drop   <= 1'b0;
                        if (rd) begin
                            r_dout <= (RDW_MODE == 1 && wr) ? w_merged : w_rdata;
                        end
                    end
                end
                default: begin
                    r_dout_valid <= 1'b0;
                    r_req_drop   <= wr | rd;
                    if (clr) begin
                        r_clr_addr <= '0;
                    end else if (r_clr_addr == c_LAST) begin
                        r_state    <= c_ST_READY;
                        r_busy     <= 1'b0;
                        r_clr_addr <= '0;
                    end else begin
                        r_clr_addr <= r_clr_addr + AWIDTH'(1);
                    end
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;
    assign req_drop   = r_req_drop;

endmodule
`default_nettype wire

// File: tb/tb_sync_ram_bwe_clr.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_ram_bwe_clr
// Description : Directed self-checking bench; one instance per read-during-write mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_ram_bwe_clr;

    localparam int c_AW = 4;
    localparam int c_DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr = 1'b0;
    logic [c_AW-1:0]   addr = '0;
    logic              wr = 1'b0;
    logic [c_DW/8-1:0] be = '0;
    logic [c_DW-1:0]   din = '0;
    logic              rd = 1'b0;

    logic [c_DW-1:0]   dout0, dout1;
    logic              v0, v1, busy0, busy1, drop0, drop1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    sync_ram_bwe_clr #(.AWIDTH(c_AW), .DWIDTH(c_DW), .RDW_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr), .addr(addr), .wr(wr), .be(be), .din(din),
        .rd(rd), .dout(dout0), .dout_valid(v0), .busy(busy0), .req_drop(drop0)
    );

    sync_ram_bwe_clr #(.AWIDTH(c_AW), .DWIDTH(c_DW), .RDW_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr), .addr(addr), .wr(wr), .be(be), .din(din),
        .rd(rd), .dout(dout1), .dout_valid(v1), .busy(busy1), .req_drop(drop1)
    );

    // Inputs change and outputs are observed on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr_cycle(input logic [c_AW-1:0] a, input logic [c_DW-1:0] d, input logic [1:0] b);
        addr = a; din = d; be = b; wr = 1'b1;
        step();
        wr = 1'b0; be = '0;
    endtask

    task automatic rd_cycle(input logic [c_AW-1:0] a);
        addr = a; rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    task automatic wait_ready(output int edges);
        edges = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (!(busy0 | busy1)) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int edges;
        @(negedge clk);
        chk_cnt++;
        if ({busy0, busy1, v0, v1, drop0, drop1, dout0, dout1} !== {2'b11, 4'b0000, 32'h0}) begin
            $display("FAIL reset_state: busy=%b%b valid=%b%b drop=%b%b dout=%h/%h, want busy=11 others 0",
                     busy0, busy1, v0, v1, drop0, drop1, dout0, dout1);
        end else pass_cnt++;
        rst = 1'b0;
        wait_ready(edges);
        chk_cnt++;
        if (edges !== 16) $display("FAIL reset_sweep_len: edges=%0d want 16", edges);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            rd_cycle(c_AW'(i));
            chk_cnt++;
            if ({v0, v1, dout0, dout1} !== {2'b11, 32'h0}) begin
                $display("FAIL reset_read_zero[%0d]: valid=%b%b dout=%h/%h want 11 0000/0000", i, v0, v1, dout0, dout1);
            end else pass_cnt++;
        end
        step();
        chk_cnt++;
        if ({v0, v1} !== 2'b00) $display("FAIL reset_valid_idle: valid=%b%b want 00", v0, v1);
        else pass_cnt++;
    endtask

    task automatic test_byte_write();
        wr_cycle(4'd3, 16'hABCD, 2'b11);
        wr_cycle(4'd3, 16'h1234, 2'b01);
        wr_cycle(4'd3, 16'h0000, 2'b00);
        rd_cycle(4'd3);
        chk_cnt++;
        if ({v0, v1, dout0, dout1} !== {2'b11, 16'hAB34, 16'hAB34}) begin
            $display("FAIL byte_write: valid=%b%b dout=%h/%h want 11 ab34/ab34", v0, v1, dout0, dout1);
        end else pass_cnt++;
        step();
        chk_cnt++;
        if ({v0, v1, dout0, dout1} !== {2'b00, 16'hAB34, 16'hAB34}) begin
            $display("FAIL dout_hold: valid=%b%b dout=%h/%h want 00 ab34/ab34", v0, v1, dout0, dout1);
        end else pass_cnt++;
    endtask

    task automatic test_rdw();
        wr_cycle(4'd5, 16'h1111, 2'b11);
        addr = 4'd5; din = 16'h2222; be = 2'b10; wr = 1'b1; rd = 1'b1;
        step();
        wr = 1'b0; rd = 1'b0; be = '0;
        chk_cnt++;
        if ({v0, v1, dout0, dout1} !== {2'b11, 16'h1111, 16'h2211}) begin
            $display("FAIL rdw_same_edge: valid=%b%b dout=%h/%h want 11 1111/2211", v0, v1, dout0, dout1);
        end else pass_cnt++;
        rd_cycle(4'd5);
        chk_cnt++;
        if ({v0, v1, dout0, dout1} !== {2'b11, 16'h2211, 16'h2211}) begin
            $display("FAIL rdw_later_read: valid=%b%b dout=%h/%h want 11 2211/2211", v0, v1, dout0, dout1);
        end else pass_cnt++;
    endtask

    task automatic test_clear();
        int edges;
        for (int i = 0; i < 16; i++) wr_cycle(c_AW'(i), 16'hFFFF, 2'b11);
        clr = 1'b1; wr = 1'b1; addr = 4'd7; din = 16'h0000; be = 2'b11;
        step();
        clr = 1'b0; wr = 1'b0; be = '0;
        chk_cnt++;
        if ({busy0, busy1, drop0, drop1, v0, v1} !== 6'b111100) begin
            $display("FAIL clr_edge_drop: busy=%b%b drop=%b%b valid=%b%b want 11 11 00",
                     busy0, busy1, drop0, drop1, v0, v1);
        end else pass_cnt++;
        step();
        step();
        chk_cnt++;
        if ({busy0, busy1, drop0, drop1} !== 4'b1100) begin
            $display("FAIL clr_idle: busy=%b%b drop=%b%b want 11 00", busy0, busy1, drop0, drop1);
        end else pass_cnt++;
        rd_cycle(4'd2);
        chk_cnt++;
        if ({busy0, busy1, drop0, drop1, v0, v1, dout0, dout1} !== {6'b111100, 16'h2211, 16'h2211}) begin
            $display("FAIL busy_read_drop: busy=%b%b drop=%b%b valid=%b%b dout=%h/%h want 11 11 00 2211/2211",
                     busy0, busy1, drop0, drop1, v0, v1, dout0, dout1);
        end else pass_cnt++;
        wait_ready(edges);
        chk_cnt++;
        if (edges !== 13) $display("FAIL clr_sweep_len: edges=%0d want 13", edges);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            rd_cycle(c_AW'(i));
            chk_cnt++;
            if ({v0, v1, drop0, drop1, dout0, dout1} !== {4'b1100, 32'h0}) begin
                $display("FAIL clr_read_zero[%0d]: valid=%b%b drop=%b%b dout=%h/%h want 11 00 0000/0000",
                         i, v0, v1, drop0, drop1, dout0, dout1);
            end else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_sweep();
        int edges;
        wr_cycle(4'd1, 16'h5A5A, 2'b11);
        rd_cycle(4'd1);
        chk_cnt++;
        if ({dout0, dout1} !== {16'h5A5A, 16'h5A5A}) $display("FAIL pre_rst_read: dout=%h/%h want 5a5a/5a5a", dout0, dout1);
        else pass_cnt++;
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        #1;
        chk_cnt++;
        if ({busy0, busy1, v0, v1, drop0, drop1, dout0, dout1} !== {2'b11, 4'b0000, 32'h0}) begin
            $display("FAIL mid_sweep_rst: busy=%b%b valid=%b%b drop=%b%b dout=%h/%h want 11 00 00 0000/0000",
                     busy0, busy1, v0, v1, drop0, drop1, dout0, dout1);
        end else pass_cnt++;
        step();
        step();
        rst = 1'b0;
        wait_ready(edges);
        chk_cnt++;
        if (edges !== 16) $display("FAIL rst_sweep_len: edges=%0d want 16", edges);
        else pass_cnt++;
        rd_cycle(4'd1);
        chk_cnt++;
        if ({v0, v1, dout0, dout1} !== {2'b11, 32'h0}) $display("FAIL post_rst_read: valid=%b%b dout=%h/%h want 11 0000/0000", v0, v1, dout0, dout1);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [c_DW-1:0] exp_word;
        for (int i = 0; i < 4; i++) wr_cycle(c_AW'(i), 16'h0A00 + c_DW'(i), 2'b11);
        rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = c_AW'(i);
            step();
            exp_word = 16'h0A00 + c_DW'(i);
            chk_cnt++;
            if ({v0, v1, drop0, drop1, dout0, dout1} !== {4'b1100, exp_word, exp_word}) begin
                $display("FAIL b2b_read[%0d]: valid=%b%b drop=%b%b dout=%h/%h want 11 00 %h/%h",
                         i, v0, v1, drop0, drop1, dout0, dout1, exp_word, exp_word);
            end else pass_cnt++;
        end
        rd = 1'b0;
        step();
        chk_cnt++;
        if ({v0, v1} !== 2'b00) $display("FAIL b2b_end: valid=%b%b want 00", v0, v1);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_rdw();
        test_clear();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
